// File: rtl/triangle_setup.sv
// Triangle setup: turns each buffered object into a bbox, three edge equations and twice the area.
// Build option TRI_CULL_EN: zero-area triangles are dropped instead of emitted.
package tri_pkg;
   localparam int COORD_W = 10;
   localparam int COLOR_W = 16;
   localparam int DEPTH_W = 16;

   typedef struct packed {
      logic [COORD_W-1:0] ax;
      logic [COORD_W-1:0] ay;
      logic [COORD_W-1:0] bx;
      logic [COORD_W-1:0] by;
      logic [COORD_W-1:0] cx;
      logic [COORD_W-1:0] cy;
      logic [COLOR_W-1:0] color;
      logic [DEPTH_W-1:0] depth;
   } object_t;
endpackage

// state  | meaning
// IDLE   | waiting for next_frame
// LOAD   | capture current object and its last flag
// STEP   | one-cycle obj_read pulse to advance the buffer
// SETUP1 | register bbox and edge A/B terms
// SETUP2 | register edge C terms and area2, normalise orientation
// EMIT   | hold record until out_ready
module triangle_setup #(
   parameter int COORD_W = tri_pkg::COORD_W
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          next_frame,
   input  tri_pkg::object_t              obj_data,
   input  logic                          obj_last,
   output logic                          obj_read,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [COORD_W-1:0]            bbox_xmin,
   output logic [COORD_W-1:0]            bbox_xmax,
   output logic [COORD_W-1:0]            bbox_ymin,
   output logic [COORD_W-1:0]            bbox_ymax,
   output logic signed [COORD_W:0]       edge0_a,
   output logic signed [COORD_W:0]       edge1_a,
   output logic signed [COORD_W:0]       edge2_a,
   output logic signed [COORD_W:0]       edge0_b,
   output logic signed [COORD_W:0]       edge1_b,
   output logic signed [COORD_W:0]       edge2_b,
   output logic signed [2*COORD_W+1:0]   edge0_c,
   output logic signed [2*COORD_W+1:0]   edge1_c,
   output logic signed [2*COORD_W+1:0]   edge2_c,
   output logic signed [2*COORD_W+1:0]   area2,
   output logic [tri_pkg::COLOR_W-1:0]   out_color,
   output logic [tri_pkg::DEPTH_W-1:0]   out_depth,
   output logic                          out_last,
   output logic                          busy,
   output logic                          frame_done
);
   localparam int AW = COORD_W + 1;
   localparam int PW = 2 * COORD_W + 2;

   typedef enum logic [2:0] {IDLE, LOAD, STEP, SETUP1, SETUP2, EMIT} state_t;

   state_t state_q, state_d;
   logic   done_q, done_d;

   logic [COORD_W-1:0]          vx_q [3];
   logic [COORD_W-1:0]          vy_q [3];
   logic [tri_pkg::COLOR_W-1:0] color_q;
   logic [tri_pkg::DEPTH_W-1:0] depth_q;
   logic                        last_q;
   logic [COORD_W-1:0]          xmin_q, xmax_q, ymin_q, ymax_q;
   logic signed [AW-1:0]        ea_q [3];
   logic signed [AW-1:0]        eb_q [3];
   logic signed [PW-1:0]        ec_q [3];
   logic signed [PW-1:0]        area_q;

   logic signed [AW-1:0]        ea_w [3];
   logic signed [AW-1:0]        eb_w [3];
   logic signed [PW-1:0]        ec_w [3];
   logic signed [PW-1:0]        area_w;
   logic                        flip_w;

   function automatic logic signed [PW-1:0] wide(input logic [COORD_W-1:0] v);
      return $signed({{(PW-COORD_W){1'b0}}, v});
   endfunction

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] p, q, r);
      logic [COORD_W-1:0] m;
      m = (p < q) ? p : q;
      return (r < m) ? r : m;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] p, q, r);
      logic [COORD_W-1:0] m;
      m = (p > q) ? p : q;
      return (r > m) ? r : m;
   endfunction

   // Edge i runs from vertex i to vertex (i+1) mod 3; products are exact in PW bits.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         ea_w[i] = $signed({1'b0, vy_q[i]}) - $signed({1'b0, vy_q[(i == 2) ? 0 : i + 1]});
         eb_w[i] = $signed({1'b0, vx_q[(i == 2) ? 0 : i + 1]}) - $signed({1'b0, vx_q[i]});
         ec_w[i] = wide(vx_q[i]) * wide(vy_q[(i == 2) ? 0 : i + 1])
                 - wide(vx_q[(i == 2) ? 0 : i + 1]) * wide(vy_q[i]);
      end
      area_w = (wide(vx_q[1]) - wide(vx_q[0])) * (wide(vy_q[2]) - wide(vy_q[0]))
             - (wide(vy_q[1]) - wide(vy_q[0])) * (wide(vx_q[2]) - wide(vx_q[0]));
      flip_w = area_w[PW-1];
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      if (next_frame) begin
         state_d = LOAD;
      end else begin
         case (state_q)
            LOAD:   state_d = STEP;
            STEP:   state_d = SETUP1;
            SETUP1: state_d = SETUP2;
            SETUP2: begin
               state_d = EMIT;
`ifdef TRI_CULL_EN
               if (area_w == '0) begin
                  state_d = last_q ? IDLE : LOAD;
                  done_d  = last_q;
               end
`endif
            end
            EMIT: begin
               if (out_ready) begin
                  state_d = last_q ? IDLE : LOAD;
                  done_d  = last_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) begin
            vx_q[i] <= '0;
            vy_q[i] <= '0;
            ea_q[i] <= '0;
            eb_q[i] <= '0;
            ec_q[i] <= '0;
         end
         color_q <= '0;
         depth_q <= '0;
         last_q  <= 1'b0;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymin_q  <= '0;
         ymax_q  <= '0;
         area_q  <= '0;
      end else begin
         case (state_q)
            LOAD: begin
               vx_q[0] <= obj_data.ax;
               vy_q[0] <= obj_data.ay;
               vx_q[1] <= obj_data.bx;
               vy_q[1] <= obj_data.by;
               vx_q[2] <= obj_data.cx;
               vy_q[2] <= obj_data.cy;
               color_q <= obj_data.color;
               depth_q <= obj_data.depth;
               last_q  <= obj_last;
            end
            SETUP1: begin
               xmin_q <= min3(vx_q[0], vx_q[1], vx_q[2]);
               xmax_q <= max3(vx_q[0], vx_q[1], vx_q[2]);
               ymin_q <= min3(vy_q[0], vy_q[1], vy_q[2]);
               ymax_q <= max3(vy_q[0], vy_q[1], vy_q[2]);
               for (int i = 0; i < 3; i++) begin
                  ea_q[i] <= ea_w[i];
                  eb_q[i] <= eb_w[i];
               end
            end
            SETUP2: begin
               // Clockwise winding is flipped so the interior is always the non-negative side.
               for (int i = 0; i < 3; i++) begin
                  ea_q[i] <= flip_w ? -ea_q[i] : ea_q[i];
                  eb_q[i] <= flip_w ? -eb_q[i] : eb_q[i];
                  ec_q[i] <= flip_w ? -ec_w[i] : ec_w[i];
               end
               area_q <= flip_w ? -area_w : area_w;
            end
            default: ;
         endcase
      end
   end

   assign obj_read   = (state_q == STEP);
   assign out_valid  = (state_q == EMIT);
   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign out_last   = last_q;
   assign out_color  = color_q;
   assign out_depth  = depth_q;
   assign bbox_xmin  = xmin_q;
   assign bbox_xmax  = xmax_q;
   assign bbox_ymin  = ymin_q;
   assign bbox_ymax  = ymax_q;
   assign edge0_a    = ea_q[0];
   assign edge1_a    = ea_q[1];
   assign edge2_a    = ea_q[2];
   assign edge0_b    = eb_q[0];
   assign edge1_b    = eb_q[1];
   assign edge2_b    = eb_q[2];
   assign edge0_c    = ec_q[0];
   assign edge1_c    = ec_q[1];
   assign edge2_c    = ec_q[2];
   assign area2      = area_q;

endmodule
